// File: rtl/sm3_cf_core_if.sv
// ---------------------------------------------------------------------------
// sm3_cf_core_if
// Handshake bundle between an SM3 hash sequencer (master) and the
// compression-function core (slave).
//
//   cf_start  master->slave  level request; a sampled rising edge launches
//   iv        master->slave  chaining value V(i), [255:224]=A ... [31:0]=H
//   block     master->slave  message block, [511:480]=W0 ... [31:0]=W15
//   hash_out  slave->master  V(i+1), same word order as iv, held until the
//                            next completion
//   cf_end    slave->master  one-cycle done pulse
// ---------------------------------------------------------------------------
interface sm3_cf_core_if;
  logic         cf_start;
  logic [255:0] iv;
  logic [511:0] block;
  logic [255:0] hash_out;
  logic         cf_end;

  modport master (
    output cf_start,
    output iv,
    output block,
    input  hash_out,
    input  cf_end
  );

  modport slave (
    input  cf_start,
    input  iv,
    input  block,
    output hash_out,
    output cf_end
  );
endinterface

// File: rtl/sm3_cf_core.sv
// ---------------------------------------------------------------------------
// sm3_cf_core
// SM3 compression function CF(V, B), one round per clock.
// A rising edge of cf_start seen in IDLE captures iv and block, the 64
// rounds run over the next 64 clocks, and one further clock publishes
// hash_out = {A..H} ^ V together with a single-cycle cf_end pulse.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    sm3_cf_core_if.slave: cf_start, iv, block in; hash_out, cf_end out
// ---------------------------------------------------------------------------
module sm3_cf_core (
  input  logic         clk,
  input  logic         reset,
  sm3_cf_core_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  localparam logic [31:0] T_LO = 32'h79cc4519;
  localparam logic [31:0] T_HI = 32'h7a879d8a;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    // A shift by 32 yields zero, so n==0 degenerates cleanly to x.
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

  logic [1:0]        state_q, state_d;
  logic              start_q, start_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [255:0]      v_q, v_d;
  // st_q[7]=A ... st_q[0]=H, so the packed value lines up with iv/hash_out.
  logic [7:0][31:0]  st_q, st_d;
  // w_q[15] holds W(j), w_q[0] holds W(j+15); the packed value lines up with block.
  logic [15:0][31:0] w_q, w_d;
  logic [255:0]      hash_q, hash_d;
  logic              cf_end_q, cf_end_d;

  logic launch;
  assign launch = (state_q == ST_IDLE) && bus.cf_start && !start_q;

  logic [31:0] w_j, w_pj, w_new;

  always_comb begin
    w_j   = w_q[15];
    w_pj  = w_q[15] ^ w_q[11];
    // W(j+16) from W(j), W(j+3), W(j+7), W(j+10), W(j+13).
    w_new = p1(w_q[15] ^ w_q[8] ^ rotl(w_q[2], 5'd15))
            ^ rotl(w_q[12], 5'd7) ^ w_q[5];
  end

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] tj, a12, ss1, ss2, ff, gg, tt1, tt2;
  logic [7:0][31:0] st_next;

  always_comb begin
    a   = st_q[7];
    b   = st_q[6];
    c   = st_q[5];
    d   = st_q[4];
    e   = st_q[3];
    f   = st_q[2];
    g   = st_q[1];
    h   = st_q[0];
    tj  = (cnt_q < 6'd16) ? T_LO : T_HI;
    a12 = rotl(a, 5'd12);
    ss1 = rotl(a12 + e + rotl(tj, cnt_q[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    if (cnt_q < 6'd16) begin
      ff = a ^ b ^ c;
      gg = e ^ f ^ g;
    end else begin
      ff = (a & b) | (a & c) | (b & c);
      gg = (e & f) | (~e & g);
    end
    tt1 = ff + d + ss2 + w_pj;
    tt2 = gg + h + ss1 + w_j;
    st_next = {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
  end

  // Control: cf_end defaults low so the FINAL pulse lasts exactly one cycle;
  // iv and block are only looked at on the launch edge.
  always_comb begin
    state_d  = state_q;
    start_d  = bus.cf_start;
    cnt_d    = cnt_q;
    v_d      = v_q;
    st_d     = st_q;
    w_d      = w_q;
    hash_d   = hash_q;
    cf_end_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          v_d     = bus.iv;
          st_d    = bus.iv;
          w_d     = bus.block;
          cnt_d   = 6'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        st_d  = st_next;
        w_d   = {w_q[14:0], w_new};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        hash_d   = st_q ^ v_q;
        cf_end_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      cnt_q    <= 6'd0;
      v_q      <= '0;
      st_q     <= '0;
      w_q      <= '0;
      hash_q   <= '0;
      cf_end_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
      st_q     <= st_d;
      w_q      <= w_d;
      hash_q   <= hash_d;
      cf_end_q <= cf_end_d;
    end
  end

  assign bus.hash_out = hash_q;
  assign bus.cf_end   = cf_end_q;

endmodule

// File: tb/tb_sm3_cf_core.sv
// ---------------------------------------------------------------------------
// tb_sm3_cf_core
// Self-checking bench for sm3_cf_core. Each launch pushes its expected hash
// onto a queue; a monitor pops and compares whenever cf_end is seen.
// Expected hashes are the published SM3 vectors or come from a reference
// CF model that expands the full 68-word schedule up front.
// ---------------------------------------------------------------------------
module tb_sm3_cf_core;

  localparam logic [255:0] IV0 =
    256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_D16 = {16{32'h61626364}};
  localparam logic [511:0] BLK_PAD = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [255:0] H_ABC =
    256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] H_TWO =
    256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   endCount;
  logic [255:0] expQ[$];

  sm3_cf_core_if bus ();

  sm3_cf_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] refP0(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction

  function automatic logic [31:0] refP1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  // Textbook SM3 compression with the whole message schedule computed first.
  function automatic logic [255:0] cfModel(input logic [255:0] vin, input logic [511:0] blk);
    logic [31:0] w [68];
    logic [31:0] wp [64];
    logic [31:0] ra, rb, rc, rd, re, rf, rg, rh;
    logic [31:0] t, s1, s2, fv, gv, x1, x2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 68; i++)
      w[i] = refP1(w[i-16] ^ w[i-9] ^ rl(w[i-3], 15)) ^ rl(w[i-13], 7) ^ w[i-6];
    for (int i = 0; i < 64; i++) wp[i] = w[i] ^ w[i+4];
    {ra, rb, rc, rd, re, rf, rg, rh} = vin;
    for (int j = 0; j < 64; j++) begin
      t  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      s1 = rl(rl(ra, 12) + re + rl(t, j), 7);
      s2 = s1 ^ rl(ra, 12);
      fv = (j < 16) ? (ra ^ rb ^ rc) : ((ra & rb) | (ra & rc) | (rb & rc));
      gv = (j < 16) ? (re ^ rf ^ rg) : ((re & rf) | (~re & rg));
      x1 = fv + rd + s2 + wp[j];
      x2 = gv + rh + s1 + w[j];
      rd = rc; rc = rl(rb, 9); rb = ra; ra = x1;
      rh = rg; rg = rl(rf, 19); rf = re; re = refP0(x2);
    end
    return {ra, rb, rc, rd, re, rf, rg, rh} ^ vin;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one launch at a falling edge and record the hash it should produce.
  task automatic applyStimulus(input logic [255:0] ivIn, input logic [511:0] blkIn,
                               input logic [255:0] expHash);
    @(negedge clk);
    bus.iv       = ivIn;
    bus.block    = blkIn;
    bus.cf_start = 1'b1;
    expQ.push_back(expHash);
  endtask

  // Waits (bounded) for cf_end; cyc is the falling-edge count after the
  // launch falling edge, 0 on timeout. mode: 0 drop start, 1 hold start,
  // 2 toggle start, 3 drop start and scramble iv/block every cycle.
  task automatic waitEnd(input int mode, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      case (mode)
        0: bus.cf_start = 1'b0;
        2: bus.cf_start = ~bus.cf_start;
        3: begin
          bus.cf_start = 1'b0;
          for (int i = 0; i < 8; i++) bus.iv[32*i +: 32] = $urandom;
          for (int i = 0; i < 16; i++) bus.block[32*i +: 32] = $urandom;
        end
        default: ;
      endcase
      if (bus.cf_end) begin
        cyc = k;
        break;
      end
    end
  endtask

  // Scoreboard monitor: every cf_end must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.cf_end) begin
      endCount++;
      if (expQ.size() == 0) checkOutput("unexpected_end", 256'd1, 256'd0);
      else checkOutput($sformatf("hash#%0d", endCount), bus.hash_out, expQ.pop_front());
    end
  end

  // Directed sequence covering the compression, chaining and handshake corners.
  initial begin
    int cyc;
    int e0;
    logic [255:0] ivR;
    logic [511:0] blkR;
    total = 0;
    bad = 0;
    endCount = 0;
    reset = 1'b0;
    bus.cf_start = 1'b0;
    bus.iv = '0;
    bus.block = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_hash", bus.hash_out, 256'd0);
    checkOutput("rst_end", {255'd0, bus.cf_end}, 256'd0);
    reset = 1'b1;

    // Single block "abc".
    e0 = endCount;
    applyStimulus(IV0, BLK_ABC, H_ABC);
    waitEnd(0, cyc);
    checkOutput("c1_latency", cyc, 66);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("c1_held", bus.hash_out, H_ABC);
    checkOutput("c1_ends", endCount - e0, 1);

    // Two-block chain, bench acting as sequencer.
    e0 = endCount;
    applyStimulus(IV0, BLK_D16, cfModel(IV0, BLK_D16));
    waitEnd(0, cyc);
    checkOutput("c2_lat1", cyc, 66);
    applyStimulus(bus.hash_out, BLK_PAD, H_TWO);
    waitEnd(0, cyc);
    checkOutput("c2_lat2", cyc, 66);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("c2_final", bus.hash_out, H_TWO);
    checkOutput("c2_ends", endCount - e0, 2);

    // cf_start held high for 300 cycles.
    e0 = endCount;
    applyStimulus(IV0, BLK_ABC, H_ABC);
    waitEnd(1, cyc);
    checkOutput("c3_latency", cyc, 66);
    repeat (300 - cyc) @(negedge clk);
    bus.cf_start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("c3_ends", endCount - e0, 1);

    // Inputs scrambled every cycle after launch.
    e0 = endCount;
    applyStimulus(IV0, BLK_ABC, H_ABC);
    waitEnd(3, cyc);
    checkOutput("c4_latency", cyc, 66);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("c4_hash", bus.hash_out, H_ABC);
    checkOutput("c4_ends", endCount - e0, 1);

    // Reset during round ~30, then launch straight out of reset.
    e0 = endCount;
    applyStimulus(IV0, BLK_ABC, H_ABC);
    @(negedge clk);
    bus.cf_start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b0;
    expQ.delete();
    bus.iv = IV0;
    bus.block = BLK_ABC;
    bus.cf_start = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("c5_rst_hash", bus.hash_out, 256'd0);
    checkOutput("c5_rst_end", {255'd0, bus.cf_end}, 256'd0);
    checkOutput("c5_no_end", endCount - e0, 0);
    @(negedge clk);
    reset = 1'b1;
    expQ.push_back(H_ABC);
    waitEnd(0, cyc);
    checkOutput("c5_latency", cyc, 66);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("c5_hash", bus.hash_out, H_ABC);
    checkOutput("c5_ends", endCount - e0, 1);

    // cf_start toggling while busy, random block checked against the model.
    e0 = endCount;
    for (int i = 0; i < 8; i++) ivR[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) blkR[32*i +: 32] = $urandom;
    applyStimulus(ivR, blkR, cfModel(ivR, blkR));
    waitEnd(2, cyc);
    checkOutput("c6_latency", cyc, 66);
    bus.cf_start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("c6_ends", endCount - e0, 1);
    applyStimulus(IV0, BLK_ABC, H_ABC);
    waitEnd(0, cyc);
    checkOutput("c6_relaunch_lat", cyc, 66);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("c6_ends2", endCount - e0, 2);

    checkOutput("sb_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
